// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
//
// Read-side drain controller for the asynchronous counting FIFO. Lives in the
// FIFO read clock domain. It pops words through the FIFO's show-ahead port and
// moves them onto a registered valid/ready stream. There are two modes:
//   - stream : pop whenever the FIFO has data and the output slot is free
//   - burst  : wait until the fill count covers a whole burst, then pop
//              exactly BURST_LEN words and flag the last one with m_tlast
//
// Parameters
//   DATA_WIDTH  word width (must match the FIFO)
//   ADDR_WIDTH  FIFO address width; fifo_count is ADDR_WIDTH+1 bits
//   BURST_LEN   beats per burst, 1 .. 2**ADDR_WIDTH
//
// Ports
//   clk          FIFO read clock
//   rst          asynchronous active-high reset
//   fifo_rd_data FIFO head word (valid whenever fifo_empty = 0)
//   fifo_empty   FIFO empty flag
//   fifo_count   conservative read-domain fill count
//   fifo_rd_en   pop strobe (combinational)
//   burst_mode   1 = burst mode, 0 = stream mode
//   m_tdata      output word (registered)
//   m_tvalid     output valid (registered)
//   m_tlast      last beat of a burst (registered)
//   m_tready     downstream accept
//   busy         high while the FSM is not idle (registered)
//   burst_count  number of completed bursts, wraps at 2**16
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int BURST_LEN  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    output logic                  fifo_rd_en,
    input  logic                  burst_mode,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  busy,
    output logic [15:0]           burst_count
);

    // Beat counter is one bit wider than needed so BURST_LEN = 1 still
    // gets a legal, non-zero-width vector.
    localparam int BEAT_W = $clog2(BURST_LEN) + 1;
    localparam logic [BEAT_W-1:0]   LAST_BEAT    = BEAT_W'(BURST_LEN - 1);
    localparam logic [ADDR_WIDTH:0] BURST_THRESH = (ADDR_WIDTH + 1)'(BURST_LEN);

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        BURST
    } state_t;

    state_t              state;
    logic [BEAT_W-1:0]   beat_cnt;
    logic                slot_free;
    logic                pop_allowed;
    logic                handshake;
    logic                last_pop;

    // The output slot can be refilled in the same cycle its word is accepted.
    // rst is folded into the pop strobe so it drops the moment reset rises,
    // without waiting for the state register to be seen as IDLE.
    always_comb begin
        slot_free   = !m_tvalid || m_tready;
        pop_allowed = (state == STREAM) || (state == BURST);
        handshake   = m_tvalid && m_tready;
        fifo_rd_en  = pop_allowed && !fifo_empty && slot_free && !rst;
        last_pop    = (state == BURST) && (beat_cnt == LAST_BEAT);
    end

    // Output register slot. A pop always wins over an accept so that
    // back-to-back words flow at one per cycle. m_tlast is cleared when the
    // slot empties so it never lingers on an invalid beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tdata     <= '0;
            m_tvalid    <= 1'b0;
            m_tlast     <= 1'b0;
            burst_count <= '0;
        end else begin
            if (fifo_rd_en) begin
                m_tdata  <= fifo_rd_data;
                m_tvalid <= 1'b1;
                m_tlast  <= last_pop;
            end else if (handshake) begin
                m_tvalid <= 1'b0;
                m_tlast  <= 1'b0;
            end

            if (handshake && m_tlast) begin
                burst_count <= burst_count + 16'd1;
            end
        end
    end

    // Mode controller. IDLE is the only place burst_mode is looked at while
    // a burst is pending, so a burst once started always runs to m_tlast.
    // A burst only starts when the conservative count covers every beat; an
    // empty flag mid-burst merely stalls popping. busy tracks the next state
    // so it stays registered and aligned with the state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            beat_cnt <= '0;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!burst_mode) begin
                        state <= STREAM;
                        busy  <= 1'b1;
                    end else if (fifo_count >= BURST_THRESH) begin
                        state    <= BURST;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                    end
                end
                STREAM: begin
                    if (burst_mode) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                BURST: begin
                    if (fifo_rd_en) begin
                        if (last_pop) begin
                            state    <= IDLE;
                            beat_cnt <= '0;
                            busy     <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    beat_cnt <= '0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed bench for fifo_burst_reader. A small show-ahead FIFO model feeds
// the DUT; every word written into it also pushes its expected beat
// ({last, data}) onto a scoreboard queue, which a negedge monitor pops on
// each output handshake. The monitor also checks that a stalled beat holds
// and that no pop happens while the slot is occupied.
// ---------------------------------------------------------------------------
module tb_fifo_burst_reader;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int BL = 4;

    logic          clk;
    logic          rst;
    logic [DW-1:0] fifo_rd_data;
    logic          fifo_empty;
    logic [AW:0]   fifo_count;
    logic          fifo_rd_en;
    logic          burst_mode;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic          busy;
    logic [15:0]   burst_count;

    int checks = 0;
    int errors = 0;
    int hs_count = 0;
    int pop_count = 0;

    // FIFO model: write pointer moved by the stimulus, read pointer by pops.
    logic [DW-1:0] mem [256];
    logic [7:0]    wr_ptr = 8'd0;
    logic [7:0]    rd_ptr = 8'd0;

    // Scoreboard of expected beats, {last, data}.
    logic [DW:0]   sb [$];

    // Monitor state for the stall-hold check.
    logic          stall_prev = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;

    fifo_burst_reader #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .BURST_LEN (BL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .fifo_rd_data(fifo_rd_data),
        .fifo_empty  (fifo_empty),
        .fifo_count  (fifo_count),
        .fifo_rd_en  (fifo_rd_en),
        .burst_mode  (burst_mode),
        .m_tdata     (m_tdata),
        .m_tvalid    (m_tvalid),
        .m_tlast     (m_tlast),
        .m_tready    (m_tready),
        .busy        (busy),
        .burst_count (burst_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign fifo_rd_data = mem[rd_ptr];
    assign fifo_empty   = (wr_ptr == rd_ptr);
    assign fifo_count   = 5'(wr_ptr - rd_ptr);

    // FIFO read side advances on every accepted pop.
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            rd_ptr    <= rd_ptr + 8'd1;
            pop_count <= pop_count + 1;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] obs,
                                input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Write one word into the FIFO model and record the beat it should become.
    task automatic apply_stimulus(input logic [DW-1:0] w, input logic last);
        mem[wr_ptr] = w;
        wr_ptr      = wr_ptr + 8'd1;
        sb.push_back({last, w});
    endtask

    // Wait (bounded) until every expected beat has been seen, then let the
    // final handshake land in the registered counters.
    task automatic wait_drain(input string tag);
        for (int i = 0; i < 80 && sb.size() != 0; i++) @(posedge clk);
        check_output(tag, 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Output monitor, sampled on the falling edge so inputs and outputs are
    // settled ahead of the next rising edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_output("stall_valid", 32'(m_tvalid), 32'd1);
                check_output("stall_data", 32'(m_tdata), 32'(prev_data));
                check_output("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && !m_tready) begin
                check_output("pop_while_full", 32'(fifo_rd_en), 32'd0);
            end
            stall_prev = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
            if (m_tvalid && m_tready) begin
                hs_count++;
                if (sb.size() == 0) begin
                    check_output("unexpected_beat", 32'(m_tdata), 32'hFFFF_FFFF);
                end else begin
                    logic [DW:0] e;
                    e = sb.pop_front();
                    check_output("beat_data", 32'(m_tdata), 32'(e[DW-1:0]));
                    check_output("beat_last", 32'(m_tlast), 32'(e[DW]));
                end
            end
        end
    end

    initial begin
        int hs0;
        int pops0;
        logic pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};

        rst        = 1'b1;
        burst_mode = 1'b0;
        m_tready   = 1'b1;

        // ---- Stream mode: 0x0001..0x0008 pre-loaded during reset ----
        for (int i = 1; i <= 8; i++) apply_stimulus(DW'(i), 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_tvalid", 32'(m_tvalid), 32'd0);
        check_output("rst_tlast", 32'(m_tlast), 32'd0);
        check_output("rst_tdata", 32'(m_tdata), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_bcount", 32'(burst_count), 32'd0);
        check_output("rst_rd_en", 32'(fifo_rd_en), 32'd0);
        hs0 = hs_count;
        rst = 1'b0;
        @(posedge clk); #1;
        check_output("stream_lat_valid0", 32'(m_tvalid), 32'd0);
        check_output("stream_lat_rd_en", 32'(fifo_rd_en), 32'd1);
        @(posedge clk); #1;
        check_output("stream_lat_valid1", 32'(m_tvalid), 32'd1);
        check_output("stream_first_data", 32'(m_tdata), 32'h0001);
        wait_drain("stream_drain");
        check_output("stream_beats", 32'(hs_count - hs0), 32'd8);
        check_output("stream_busy", 32'(busy), 32'd1);

        // ---- Burst mode: count climbs 0..3 without pops, then 4 ----
        burst_mode = 1'b1;
        repeat (3) @(posedge clk); #1;
        check_output("idle_busy", 32'(busy), 32'd0);
        pops0 = pop_count;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(DW'(16'hA0 + i), 1'b0);
            repeat (2) @(posedge clk); #1;
        end
        check_output("below_thresh_pops", 32'(pop_count - pops0), 32'd0);
        apply_stimulus(16'h00A3, 1'b1);
        wait_drain("burst1_drain");
        check_output("burst1_pops", 32'(pop_count - pops0), 32'd4);
        check_output("burst1_count", 32'(burst_count), 32'd1);
        check_output("burst1_busy", 32'(busy), 32'd0);

        // ---- Burst with m_tready toggling 1,0,0,1 ----
        for (int i = 0; i < 4; i++) apply_stimulus(DW'(16'hB0 + i), i == 3);
        for (int i = 0; i < 20; i++) begin
            m_tready = pat[i % 4];
            @(posedge clk); #1;
        end
        m_tready = 1'b1;
        wait_drain("burst2_drain");
        check_output("burst2_count", 32'(burst_count), 32'd2);

        // ---- burst_mode dropped mid-burst: burst finishes, then stream ----
        for (int i = 0; i < 4; i++) apply_stimulus(DW'(16'hC0 + i), i == 3);
        apply_stimulus(16'h00C4, 1'b0);
        apply_stimulus(16'h00C5, 1'b0);
        repeat (2) @(posedge clk); #1;
        check_output("mid_burst_busy", 32'(busy), 32'd1);
        burst_mode = 1'b0;
        wait_drain("switch_drain");
        check_output("switch_count", 32'(burst_count), 32'd3);
        check_output("switch_busy", 32'(busy), 32'd1);

        // ---- fifo_count = 8: two back-to-back bursts ----
        burst_mode = 1'b1;
        repeat (3) @(posedge clk); #1;
        for (int i = 0; i < 8; i++) apply_stimulus(DW'(16'hD0 + i), (i % 4) == 3);
        wait_drain("b2b_drain");
        check_output("b2b_count", 32'(burst_count), 32'd5);
        check_output("b2b_busy", 32'(busy), 32'd0);

        // ---- Reset mid-burst with a stalled beat ----
        m_tready = 1'b0;
        for (int i = 0; i < 4; i++) apply_stimulus(DW'(16'hE0 + i), i == 3);
        repeat (3) @(posedge clk);
        #2;
        check_output("pre_rst_valid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        check_output("midrst_tvalid", 32'(m_tvalid), 32'd0);
        check_output("midrst_tlast", 32'(m_tlast), 32'd0);
        check_output("midrst_tdata", 32'(m_tdata), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        check_output("midrst_bcount", 32'(burst_count), 32'd0);
        check_output("midrst_rd_en", 32'(fifo_rd_en), 32'd0);
        // E0 was popped before reset and is gone; E1..E3 remain in the FIFO.
        sb.delete();
        sb.push_back({1'b0, 16'h00E1});
        sb.push_back({1'b0, 16'h00E2});
        sb.push_back({1'b0, 16'h00E3});
        apply_stimulus(16'h00E4, 1'b1);
        @(posedge clk); #1;
        rst      = 1'b0;
        m_tready = 1'b1;
        wait_drain("post_rst_drain");
        check_output("post_rst_count", 32'(burst_count), 32'd1);
        check_output("post_rst_busy", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side drain controller for the asynchronous counting FIFO. Sits in the FIFO read clock domain. It pops words through the FIFO's show-ahead read port (`rd_data` valid whenever `empty`=0, `rd_en` advances) and re-times them onto a registered valid/ready stream. It offers two modes:
- free-running streaming;
- fixed-length bursts that start only when the FIFO's read-domain fill count guarantees a whole burst, with `m_tlast` on the final beat.

## Interface
Parameters
- `DATA_WIDTH`, 16, word width; must match the FIFO.
- `ADDR_WIDTH`, 4, FIFO address width; count input is `ADDR_WIDTH+1` bits.
- `BURST_LEN`, 4, beats per burst; legal range 1..2^ADDR_WIDTH.

Ports
- `clk`  in  1  FIFO read clock.
- `rst`  in  1  asynchronous, active-high reset.
- `fifo_rd_data`  in  DATA_WIDTH  FIFO head word (show-ahead).
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_count`  in  ADDR_WIDTH+1  FIFO read-domain fill count (conservative: never exceeds true occupancy).
- `fifo_rd_en`  out  1  pop strobe; combinational.
- `burst_mode`  in  1  1 = burst mode, 0 = stream mode.
- `m_tdata`  out  DATA_WIDTH  output word; registered.
- `m_tvalid`  out  1  output valid; registered.
- `m_tlast`  out  1  last beat of a burst; registered.
- `m_tready`  in  1  downstream accept.
- `busy`  out  1  high while state is not IDLE; registered.
- `burst_count`  out  16  completed bursts; wraps modulo 2^16.

## Operation
- Single output register slot.
  - Slot is free when `m_tvalid`=0, or when `m_tvalid`=1 and `m_tready`=1 (same-cycle refill allowed).
  - Handshake occurs when `m_tvalid` and `m_tready` are both 1.
- `fifo_rd_en` = `pop_allowed` & ~`fifo_empty` & slot free.
  - On `fifo_rd_en`, the register loads `fifo_rd_data` and sets `m_tvalid`=1.
  - On a handshake with no pop, `m_tvalid` goes to 0.
  - `m_tdata` and `m_tlast` hold while `m_tvalid`=1 and `m_tready`=0.
- State machine: IDLE, STREAM, BURST.
  - IDLE, `pop_allowed`=0.
    - `burst_mode`=0 -> STREAM.
    - `burst_mode`=1 and `fifo_count` >= BURST_LEN -> BURST; beat counter cleared to 0.
    - Otherwise stay in IDLE.
  - STREAM, `pop_allowed`=1.
    - Words are loaded with `m_tlast`=0.
    - `burst_mode`=1 sampled -> IDLE. A word popped in that same cycle is still loaded.
  - BURST, `pop_allowed`=1.
    - Each pop increments the beat counter (width clog2(BURST_LEN)+1).
    - The pop with beat counter = BURST_LEN-1 loads `m_tlast`=1 and moves the FSM to IDLE.
    - `burst_mode` is ignored until the burst finishes.
    - `fifo_empty`=1 mid-burst stalls popping without leaving BURST. This cannot occur with a conservative count, but it must be tolerated.
- `burst_count` increments on each handshake with `m_tlast`=1.
- Comparison `fifo_count` >= BURST_LEN is unsigned at ADDR_WIDTH+1 bits.
- Back-to-back bursts:
  - IDLE re-evaluates on the cycle after the last pop.
  - The next burst may start while the last beat of the previous burst is still stalled in the register.
  - Its first pop waits for the slot to be free.

## Timing
- Reset values: `m_tvalid`=0, `m_tlast`=0, `m_tdata`=0, `busy`=0, `burst_count`=0, state IDLE, beat counter 0.
  - `fifo_rd_en`=0 during reset.
- Latency, stream mode: word at FIFO head with `fifo_empty`=0 in cycle N (state STREAM, slot free) -> `fifo_rd_en`=1 in N -> `m_tvalid`=1 with that word in N+1.
- Entering a mode from IDLE costs 1 cycle: first pop happens the cycle after the IDLE decision.
- Throughput: 1 word/cycle sustained while `m_tready`=1 and FIFO non-empty.
- Reset mid-burst: output register and FSM clear immediately.
  - Words already popped are lost.
  - `fifo_rd_en` drops asynchronously with reset.

## Test plan
- Stream mode, `m_tready`=1, FIFO supplies 0x0001..0x0008 -> 8 consecutive `m_tvalid` beats in order, `m_tlast`=0, first beat 2 cycles after `burst_mode`=0 out of reset.
- Burst mode, BURST_LEN=4, `fifo_count` rises 0->3 -> no pops. Count reaches 4 -> exactly 4 pops, beats 0xA0..0xA3, `m_tlast` only on 0xA3, `burst_count`=1, `busy` back to 0.
- Burst mode with `m_tready` toggling 1,0,0,1 -> no word dropped or duplicated, `m_tdata` stable while stalled, `fifo_rd_en` never asserted while the slot is occupied.
- `burst_mode` switched 1->0 in the middle of a burst -> burst completes all 4 beats with `m_tlast`, then IDLE, then STREAM.
- `fifo_count`=8 in burst mode -> two back-to-back bursts, `burst_count`=2, `m_tlast` on beats 4 and 8.
- `rst` asserted mid-burst with a stalled beat -> all outputs 0 immediately. After release, with `fifo_count`>=4, a fresh burst runs with beat counter restarting at 0.
